// File: rtl/div_if.sv
// Handshake bundle between the EX-stage decoder/forwarding logic and the
// divide sequencer.
//   start     decoder: EX instruction is a divide
//   div_mode  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a      dividend (rs1 after forwarding)
//   op_b      divisor  (rs2 after forwarding)
//   flush     kill the EX instruction / abort the divide
//   stall     freeze PC/IF/ID/EX (combinational)
//   done      one-cycle pulse, result valid
//   result    quotient or remainder, held until the next completion
interface div_if;
    logic        start;
    logic [1:0]  div_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, div_mode, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, div_mode, op_a, op_b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-iteration radix-2 restoring divide
// with a single-edge fast path for divide-by-zero and signed overflow.
// Holds the pipeline with stall until the result is presented in DONE.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    div_if.slave: start/div_mode/op_a/op_b/flush in,
//          stall/done/result out
module div_sequencer (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] q;          // dividend magnitude shifting out, quotient shifting in
    logic [32:0] r;          // partial remainder
    logic [31:0] b_mag;
    logic        neg_q, neg_r;
    logic [1:0]  mode;
    logic [31:0] result_q;

    logic        launch, div_zero, ovf, sgn_in, a_neg, b_neg;
    logic [31:0] a_mag_in, b_mag_in;
    logic [32:0] r_sh, r_step;
    logic [31:0] q_step, quo, rem;
    logic        fits, stall_c, done_c;

    // Launch decode and operand magnitudes.
    always_comb begin
        sgn_in   = ~bus.div_mode[0];
        a_neg    = sgn_in & bus.op_a[31];
        b_neg    = sgn_in & bus.op_b[31];
        a_mag_in = a_neg ? -bus.op_a : bus.op_a;
        b_mag_in = b_neg ? -bus.op_b : bus.op_b;
        launch   = (state == IDLE) && bus.start && !bus.flush;
        div_zero = (bus.op_b == 32'd0);
        ovf      = sgn_in && (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
    end

    // One restoring-division step plus the final sign correction.
    always_comb begin
        r_sh   = {r[31:0], q[31]};
        fits   = (r_sh >= {1'b0, b_mag});
        r_step = fits ? (r_sh - {1'b0, b_mag}) : r_sh;
        q_step = {q[30:0], fits};
        quo    = neg_q ? -q : q;
        rem    = neg_r ? -r[31:0] : r[31:0];
    end

    // Next state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        state_nx = state;
        case (state)
            IDLE: if (launch) state_nx = (div_zero || ovf) ? DONE : CALC;
            CALC: if (cnt == 5'd0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;   // start ignored: same instruction still in EX
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;

        stall_c = rst_n && !bus.flush &&
                  ((state == CALC) || (state == FIX) || ((state == IDLE) && bus.start));
        done_c  = (state == DONE) && !bus.flush;
    end

    assign bus.stall  = stall_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            b_mag    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mode     <= '0;
            result_q <= '0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: if (launch) begin
                    mode  <= bus.div_mode;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    b_mag <= b_mag_in;
                    q     <= a_mag_in;
                    r     <= '0;
                    cnt   <= 5'd31;
                    if (div_zero)
                        result_q <= bus.div_mode[1] ? bus.op_a : 32'hFFFF_FFFF;
                    else if (ovf)
                        result_q <= bus.div_mode[1] ? 32'd0 : 32'h8000_0000;
                end
                CALC: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt - 5'd1;
                end
                FIX:  result_q <= mode[1] ? rem : quo;
                default: ;
            endcase
        end
    end
endmodule
